// File: rtl/aes_sub_bytes_fwd.sv
// rtl/aes_sub_bytes_fwd.sv - forward AES SubBytes engine, one registered S-box lookup per clock
module aes_sub_bytes_fwd #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Start,
    input  logic [8*NUM_BYTES-1:0] Data_In,
    output logic                   Busy,
    output logic                   Done,
    output logic [8*NUM_BYTES-1:0] Data_Out
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DRAIN
    } state_t;

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t          state;
    logic [IW-1:0]   index;
    logic [W-1:0]    src;
    logic [W-1:0]    result;
    logic [7:0]      sbox_q;
    logic [7:0]      sbox_addr;
    logic [10:0]     sbox_base;

    // The source register shifts left one byte per lookup, so the byte
    // being looked up is always the top byte; ~addr*8 locates it in SBOX.
    assign sbox_addr = src[W-1 -: 8];
    assign sbox_base = {~sbox_addr, 3'b000};

    // Registered S-box read: one clock of latency from address to sbox_q
    always_ff @(posedge CLK) begin
        if (RST) begin
            sbox_q <= 8'h00;
        end else begin
            sbox_q <= SBOX[sbox_base +: 8];
        end
    end

    // Control FSM: capture, stream bytes through the S-box, publish the result
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            index    <= '0;
            src      <= '0;
            result   <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Data_Out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        src   <= Data_In;
                        index <= '0;
                        Busy  <= 1'b1;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    src <= {src[W-9:0], 8'h00};
                    // sbox_q holds the previous byte's substitution from t2 on
                    if (index != '0) begin
                        result <= {result[W-9:0], sbox_q};
                    end
                    index <= index + 1'b1;
                    if (index == IW'(NUM_BYTES - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    result   <= {result[W-9:0], sbox_q};
                    Data_Out <= {result[W-9:0], sbox_q};
                    Done     <= 1'b1;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_fwd.sv
// tb/tb_aes_sub_bytes_fwd.sv - directed self-checking bench for aes_sub_bytes_fwd
module tb_aes_sub_bytes_fwd;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [127:0] Data_In;
    logic         Busy;
    logic         Done;
    logic [127:0] Data_Out;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] FIPS_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] BND_IN    = 128'h00ff525300ff525300ff525300ff5253;
    localparam logic [127:0] BND_OUT   = 128'h631600ed631600ed631600ed631600ed;
    localparam logic [127:0] SEQ_IN    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ_OUT   = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ONES_IN   = 128'h01010101010101010101010101010101;
    localparam logic [127:0] ONES_OUT  = 128'h7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c;

    aes_sub_bytes_fwd #(.NUM_BYTES(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .Data_In  (Data_In),
        .Busy     (Busy),
        .Done     (Done),
        .Data_Out (Data_Out)
    );

    always #5 CLK = ~CLK;

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one operation at the current negedge and follow it to its Done.
    // prev is the Data_Out value that must stay visible while the op runs.
    task automatic run_op(input string tag, input logic [127:0] din, input logic [127:0] exp,
                          input logic [127:0] prev, input bit inject);
        int early_done = 0;
        int busy_low   = 0;
        int out_moved  = 0;
        Start   = 1'b1;
        Data_In = din;
        for (int n = 1; n <= 19; n++) begin
            @(negedge CLK);
            if (n < 18) begin
                if (Done)            early_done++;
                if (!Busy)           busy_low++;
                if (Data_Out !== prev) out_moved++;
            end
            if (n == 18) begin
                check1({tag, "_done"}, Done, 1'b1);
                check1({tag, "_busy_at_done"}, Busy, 1'b0);
                check128({tag, "_data"}, Data_Out, exp);
            end
            if (n == 19) begin
                check1({tag, "_done_one_cycle"}, Done, 1'b0);
            end
            if (n == 1) begin
                Start   = 1'b0;
                Data_In = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            end
            if (inject && (n == 3 || n == 10)) begin
                Start   = 1'b1;
                Data_In = {16{8'hff}};
            end
            if (inject && (n == 4 || n == 11)) begin
                Start = 1'b0;
            end
        end
        check_int({tag, "_early_done"}, early_done, 0);
        check_int({tag, "_busy_low_in_op"}, busy_low, 0);
        check_int({tag, "_data_out_moved"}, out_moved, 0);
    endtask

    initial begin
        int done_seen;
        int d1;
        int d2;
        int busy_bad;
        logic [127:0] cap1;
        logic [127:0] cap2;

        RST     = 1'b1;
        Start   = 1'b0;
        Data_In = '0;

        // 1. reset state, then idle with no spurious Done
        repeat (2) @(negedge CLK);
        check1("rst_busy", Busy, 1'b0);
        check1("rst_done", Done, 1'b0);
        check128("rst_data", Data_Out, 128'h0);
        RST = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done) done_seen++;
        end
        check_int("idle_no_done", done_seen, 0);

        // 2. FIPS-197 round-1 SubBytes
        run_op("fips", FIPS_IN, FIPS_OUT, 128'h0, 1'b0);

        // 3. boundary bytes 00, FF, 52, 53
        run_op("boundary", BND_IN, BND_OUT, FIPS_OUT, 1'b0);

        // 4. Start pulses during the op are ignored
        run_op("ignore", SEQ_IN, SEQ_OUT, BND_OUT, 1'b1);
        done_seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Done) done_seen++;
        end
        check_int("ignore_no_second_done", done_seen, 0);
        check128("ignore_data_held", Data_Out, SEQ_OUT);

        // 5. Start held high: two results back to back
        Start    = 1'b1;
        Data_In  = FIPS_IN;
        d1       = 0;
        d2       = 0;
        busy_bad = 0;
        cap1     = '0;
        cap2     = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (n <= 36 && Busy !== ~Done) busy_bad++;
            if (Done) begin
                if (d1 == 0) begin
                    d1   = n;
                    cap1 = Data_Out;
                end else if (d2 == 0) begin
                    d2   = n;
                    cap2 = Data_Out;
                end
            end
            if (n == 1)  Data_In = ONES_IN;
            if (n == 19) Start = 1'b0;
        end
        check_int("b2b_first_done_cycle", d1, 18);
        check_int("b2b_second_done_cycle", d2, 36);
        check128("b2b_first_data", cap1, FIPS_OUT);
        check128("b2b_second_data", cap2, ONES_OUT);
        check_int("b2b_busy_vs_done", busy_bad, 0);

        // 6. reset in the middle of an operation
        Start   = 1'b1;
        Data_In = SEQ_IN;
        @(negedge CLK);
        Start = 1'b0;
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check1("midrst_busy", Busy, 1'b0);
        check1("midrst_done", Done, 1'b0);
        check128("midrst_data", Data_Out, 128'h0);
        RST = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Done) done_seen++;
        end
        check_int("midrst_no_done", done_seen, 0);
        check1("midrst_idle_busy", Busy, 1'b0);
        run_op("after_rst", FIPS_IN, FIPS_OUT, 128'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
